id_ex_elastic_reg: RTL and testbench
====================================

# id_ex_elastic_reg

Elastic, parametrised pipeline stage register that generalises the fixed ID→EX latch into a valid/ready stage. It accepts a packed payload (PC, register indices, control flags, operands) from the decode side and presents it to execute one cycle later. It adds a two-entry skid buffer for downstream back-pressure without a combinational ready path, a synchronous flush for branch/jump squash, and an occupancy output for hazard logic.

## Interface
Parameters:
- NBITS, 32 — width of the packed payload carried through the stage (≥1).

Ports:
- i_clk  in  1  — clock; all state updates on rising edge.
- i_rst  in  1  — synchronous, active-high reset.
- i_flush  in  1  — squash: discard all held entries and any input offered this cycle.
- i_valid  in  1  — upstream (ID) payload valid.
- o_ready  out  1  — stage can accept a payload this cycle.
- i_data  in  NBITS  — upstream payload.
- o_valid  out  1  — payload on o_data is valid for EX.
- i_ready  in  1  — downstream (EX) accepts o_data this cycle.
- o_data  out  NBITS  — payload presented to EX.
- o_count  out  2  — entries held: 0, 1 or 2.

## Operation
- Storage: main register (drives o_data) and skid register; state register {EMPTY, ONE, FULL}.
- Transfer in = i_valid & o_ready; transfer out = o_valid & i_ready.
- Outputs decoded from state only: EMPTY → o_valid=0, o_ready=1, o_count=0; ONE → 1,1,1; FULL → 1,0,2.
- EMPTY: i_valid → main<=i_data, go ONE; else stay.
- ONE:
  - i_valid & i_ready → main<=i_data, stay ONE.
  - i_valid & !i_ready → skid<=i_data, go FULL.
  - !i_valid & i_ready → go EMPTY.
  - neither → hold.
- FULL: i_ready → main<=skid, go ONE; else hold. i_valid/i_data ignored (o_ready=0).
- Priority: i_rst > i_flush > normal operation.
- i_flush: next state EMPTY; main and skid cleared to 0; input this cycle not captured even if i_valid=1; downstream handshake this cycle still counts as completed for EX but the stage holds nothing afterwards.
- Ordering strictly FIFO; no payload duplicated or dropped except via flush/reset.
- Payload bits are opaque; no arithmetic on data.

## Timing
- Reset: state EMPTY, main=0, skid=0 → o_valid=0, o_ready=1, o_data=0, o_count=0 from first cycle after reset edge.
- Reset mid-operation: both entries lost, identical to power-on reset.
- Latency: payload accepted at edge N appears on o_data with o_valid=1 after edge N (visible in cycle N+1).
- Throughput: one payload per cycle while i_ready=1.
- o_ready is a registered-state function; no combinational path i_ready→o_ready or i_valid→o_valid.
- o_data changes only on: load into main, skid→main move, flush, reset.
- Back-pressure: one extra payload absorbed after i_ready falls (the one offered while o_ready was still 1); o_ready drops the following cycle.
- FULL with i_ready=1: o_ready returns to 1 the next cycle; no new payload accepted in the draining cycle.
- Flush in FULL or ONE: o_valid=0 next cycle regardless of i_valid.

## Test plan
- Reset: drive i_valid=1, i_data=0xDEADBEEF with i_rst=1 → after release o_valid=0, o_ready=1, o_data=0, o_count=0.
- Streaming: i_ready=1, push 0x1,0x2,0x3 back-to-back → o_data 0x1,0x2,0x3 on consecutive cycles one cycle after each, o_count=1 throughout.
- Back-pressure: push 0xA then 0xB with i_ready=0 → o_count 1 then 2, o_ready=0, o_data=0xA held; raise i_ready → 0xA then 0xB out in order, o_ready back to 1 one cycle after 0xA leaves.
- Flush in FULL: state FULL (0xA, 0xB), assert i_flush with i_valid=1, i_data=0xC → next cycle o_valid=0, o_count=0, o_data=0; 0xC never appears.
- Drain to empty: one entry 0x5, i_valid=0, i_ready=1 → o_valid=0 next cycle, o_count=0.
- Randomised valid/ready (NBITS=8 and 64) against scoreboard → output sequence equals accepted input sequence, o_count never >2.

Source files
------------

// File: rtl/id_ex_elastic_reg_if.sv
// Handshake bundle between the decode side (master) and the ID/EX elastic
// stage (slave). Signal names keep the stage-relative i_/o_ direction prefixes.
interface id_ex_elastic_reg_if #(
    parameter int NBITS = 32
);
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [NBITS-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [NBITS-1:0] o_data;
    logic [1:0]       o_count;

    modport master (
        output i_flush, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_flush, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID->EX elastic pipeline register: a main register feeding EX plus a skid
// register that absorbs the one payload in flight when EX stalls. All
// handshake outputs decode from the state register only, so there is no
// combinational path from i_ready to o_ready or from i_valid to o_valid.
module id_ex_elastic_reg #(
    parameter int NBITS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    id_ex_elastic_reg_if.slave   ifc
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] main_q,  main_d;
    logic [NBITS-1:0] skid_q,  skid_d;

    // Next-state and storage update; flush empties the stage and ignores the
    // input offered in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (ifc.i_flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (ifc.i_valid) begin
                        main_d  = ifc.i_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (ifc.i_valid && ifc.i_ready) begin
                        main_d  = ifc.i_data;
                        state_d = ST_ONE;
                    end else if (ifc.i_valid) begin
                        skid_d  = ifc.i_data;
                        state_d = ST_FULL;
                    end else if (ifc.i_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // Input is not accepted here (o_ready is low).
                    if (ifc.i_ready) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Handshake and occupancy outputs decoded purely from the state register.
    always_comb begin
        ifc.o_valid = 1'b0;
        ifc.o_ready = 1'b1;
        ifc.o_count = 2'd0;
        case (state_q)
            ST_EMPTY: begin
                ifc.o_valid = 1'b0;
                ifc.o_ready = 1'b1;
                ifc.o_count = 2'd0;
            end
            ST_ONE: begin
                ifc.o_valid = 1'b1;
                ifc.o_ready = 1'b1;
                ifc.o_count = 2'd1;
            end
            ST_FULL: begin
                ifc.o_valid = 1'b1;
                ifc.o_ready = 1'b0;
                ifc.o_count = 2'd2;
            end
            default: begin
                ifc.o_valid = 1'b0;
                ifc.o_ready = 1'b1;
                ifc.o_count = 2'd0;
            end
        endcase
    end

    assign ifc.o_data = main_q;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: two instances (64-bit and 8-bit payload) share
// the same handshake stimulus. A queue-based reference model of the stage
// (at most two entries, FIFO order, last presented value held) is compared
// every cycle, plus directed checks for reset, streaming, back-pressure,
// flush and drain.
module tb_id_ex_elastic_reg;

    logic i_clk;
    logic i_rst;

    id_ex_elastic_reg_if #(.NBITS(64)) bus64 ();
    id_ex_elastic_reg_if #(.NBITS(8))  bus8 ();

    id_ex_elastic_reg #(.NBITS(64)) dut64 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .ifc   (bus64)
    );

    id_ex_elastic_reg #(.NBITS(8)) dut8 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .ifc   (bus8)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: held entries oldest first, and the value on o_data.
    logic [63:0] mq[$];
    logic [63:0] shown;
    bit          model_known = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        if (model_known) begin
            chk("m_valid64", 64'(bus64.o_valid), 64'(mq.size() > 0));
            chk("m_ready64", 64'(bus64.o_ready), 64'(mq.size() < 2));
            chk("m_count64", 64'(bus64.o_count), 64'(mq.size()));
            chk("m_data64",  bus64.o_data, shown);
            chk("m_valid8",  64'(bus8.o_valid), 64'(mq.size() > 0));
            chk("m_ready8",  64'(bus8.o_ready), 64'(mq.size() < 2));
            chk("m_count8",  64'(bus8.o_count), 64'(mq.size()));
            chk("m_data8",   64'(bus8.o_data), 64'(shown[7:0]));
        end
    endtask

    task automatic model_step(input logic rst, input logic flush, input logic v,
                              input logic [63:0] d, input logic r);
        bit take_out;
        bit take_in;
        if (rst || flush) begin
            mq.delete();
            shown       = 64'd0;
            model_known = 1'b1;
        end else begin
            take_out = (mq.size() > 0) && r;
            take_in  = v && (mq.size() < 2);
            if (take_out) void'(mq.pop_front());
            if (take_in) mq.push_back(d);
            if (mq.size() > 0) shown = mq[0];
        end
    endtask

    // One clock cycle: drive inputs, check model before the edge, advance model.
    task automatic cycle(input logic rst, input logic flush, input logic v,
                         input logic [63:0] d, input logic r);
        i_rst         = rst;
        bus64.i_flush = flush;
        bus64.i_valid = v;
        bus64.i_data  = d;
        bus64.i_ready = r;
        bus8.i_flush  = flush;
        bus8.i_valid  = v;
        bus8.i_data   = d[7:0];
        bus8.i_ready  = r;
        #1;
        model_check();
        @(posedge i_clk);
        model_step(rst, flush, v, d, r);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic rdy,
                           input logic [1:0] cnt, input logic [63:0] d);
        chk({tag, "_valid"}, 64'(bus64.o_valid), 64'(v));
        chk({tag, "_ready"}, 64'(bus64.o_ready), 64'(rdy));
        chk({tag, "_count"}, 64'(bus64.o_count), 64'(cnt));
        chk({tag, "_data"},  bus64.o_data, d);
    endtask

    initial begin
        logic        rv;
        logic        rr;
        logic        rf;
        logic        rs;
        logic [63:0] rd;

        // Reset with a payload offered: nothing may be captured.
        cycle(1'b1, 1'b0, 1'b1, 64'hDEADBEEF, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 64'hDEADBEEF, 1'b0);
        chk_out("reset", 1'b0, 1'b1, 2'd0, 64'd0);

        // Streaming with EX always ready.
        cycle(1'b0, 1'b0, 1'b1, 64'h1, 1'b1);
        chk_out("stream1", 1'b1, 1'b1, 2'd1, 64'h1);
        cycle(1'b0, 1'b0, 1'b1, 64'h2, 1'b1);
        chk_out("stream2", 1'b1, 1'b1, 2'd1, 64'h2);
        cycle(1'b0, 1'b0, 1'b1, 64'h3, 1'b1);
        chk_out("stream3", 1'b1, 1'b1, 2'd1, 64'h3);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk_out("stream_end", 1'b0, 1'b1, 2'd0, 64'h3);

        // Back-pressure: second payload lands in the skid register.
        cycle(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
        chk_out("bp_one", 1'b1, 1'b1, 2'd1, 64'hA);
        cycle(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
        chk_out("bp_full", 1'b1, 1'b0, 2'd2, 64'hA);
        cycle(1'b0, 1'b0, 1'b1, 64'hE, 1'b0);
        chk_out("bp_hold", 1'b1, 1'b0, 2'd2, 64'hA);
        cycle(1'b0, 1'b0, 1'b1, 64'hF, 1'b1);
        chk_out("bp_drainA", 1'b1, 1'b1, 2'd1, 64'hB);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk_out("bp_drainB", 1'b0, 1'b1, 2'd0, 64'hB);

        // Flush while FULL with a new payload offered.
        cycle(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
        chk_out("fl_pre", 1'b1, 1'b0, 2'd2, 64'hA);
        cycle(1'b0, 1'b1, 1'b1, 64'hC, 1'b0);
        chk_out("fl_post", 1'b0, 1'b1, 2'd0, 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk_out("fl_noC", 1'b0, 1'b1, 2'd0, 64'h0);

        // Drain a single entry to empty; o_data keeps the last value.
        cycle(1'b0, 1'b0, 1'b1, 64'h5, 1'b0);
        chk_out("dr_one", 1'b1, 1'b1, 2'd1, 64'h5);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        chk_out("dr_empty", 1'b0, 1'b1, 2'd0, 64'h5);

        // Randomised valid/ready with occasional flush and reset, in phases of
        // different valid/ready bias.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 800; i++) begin
                rv = ($urandom_range(3) >= ((ph == 1) ? 3 : 1)) ? 1'b1 : 1'b0;
                rr = ($urandom_range(3) >= ((ph == 2) ? 3 : 1)) ? 1'b1 : 1'b0;
                rf = ($urandom_range(40) == 0) ? 1'b1 : 1'b0;
                rs = ($urandom_range(250) == 0) ? 1'b1 : 1'b0;
                rd = {$urandom, $urandom};
                cycle(rs, rf, rv, rd, rr);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
